// File: rtl/byte_serial_add32_ctrl.sv
// byte_serial_add32_ctrl
// Multi-cycle WIDTH-bit adder/subtractor. One SLICE-bit ripple slice is
// reused over NSLICE cycles, with the inter-slice carry kept in a register.
// Results (sum, cout, ovf) are registered and held until the next operation
// completes. A start/done handshake connects it to the issuing unit.

module byte_serial_add32_ctrl #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [IDXW-1:0] IDX_ZERO = IDXW'(0);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One ripple slice. Result layout: {carry out, carry into slice MSB, sum}.
    // The carry into the MSB is kept so signed overflow can be derived from
    // the top slice without a second adder.
    function automatic logic [SLICE+1:0] slice_add(
        input logic [SLICE-1:0] a,
        input logic [SLICE-1:0] b,
        input logic             c
    );
        logic [SLICE-2:0] low;
        logic             c_msb;
        logic             s_msb;
        logic             c_out;
        {c_msb, low}   = {1'b0, a[SLICE-2:0]} + {1'b0, b[SLICE-2:0]}
                       + {{(SLICE-1){1'b0}}, c};
        {c_out, s_msb} = {1'b0, a[SLICE-1]} + {1'b0, b[SLICE-1]} + {1'b0, c_msb};
        return {c_out, c_msb, s_msb, low};
    endfunction

    state_t           state_r;
    logic [IDXW-1:0]  idx_r;
    logic             carry_r;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic [WIDTH-1:0] work_r;

    logic [SLICE-1:0] opa_sl_s [NSLICE];
    logic [SLICE-1:0] opb_sl_s [NSLICE];
    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE+1:0] res_s;
    logic [WIDTH-1:0] merged_s;
    logic             last_s;

    // Select the active slice, add it, and merge its sum into the working word.
    always_comb begin
        for (int i = 0; i < NSLICE; i++) begin
            opa_sl_s[i] = opa_r[i*SLICE +: SLICE];
            opb_sl_s[i] = opb_r[i*SLICE +: SLICE];
        end
        a_s      = opa_sl_s[idx_r];
        b_s      = opb_sl_s[idx_r];
        res_s    = slice_add(a_s, b_s, carry_r);
        merged_s = work_r;
        for (int i = 0; i < NSLICE; i++) begin
            merged_s[i*SLICE +: SLICE] = (idx_r == IDXW'(i)) ? res_s[SLICE-1:0]
                                                             : work_r[i*SLICE +: SLICE];
        end
        last_s   = (idx_r == IDX_LAST);
    end

    // Control FSM, operand capture, slice sequencing and registered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= IDX_ZERO;
            carry_r <= 1'b0;
            opa_r   <= {WIDTH{1'b0}};
            opb_r   <= {WIDTH{1'b0}};
            work_r  <= {WIDTH{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= {WIDTH{1'b0}};
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        // Subtract is x + ~y + 1; cin is ignored in that mode.
                        opa_r   <= x;
                        opb_r   <= sub ? ~y : y;
                        carry_r <= sub ? 1'b1 : cin;
                        idx_r   <= IDX_ZERO;
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    work_r  <= merged_s;
                    carry_r <= res_s[SLICE+1];
                    if (last_s) begin
                        // Only the completing edge touches the visible result.
                        sum     <= merged_s;
                        cout    <= res_s[SLICE+1];
                        ovf     <= res_s[SLICE+1] ^ res_s[SLICE];
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        idx_r   <= IDX_ZERO;
                        state_r <= IDLE;
                    end else begin
                        idx_r   <= idx_r + IDX_ONE;
                        state_r <= RUN;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    idx_r   <= IDX_ZERO;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/byte_serial_add32_ctrl.md
Name: byte_serial_add32_ctrl

Overview:
- Multi-cycle controller that performs a WIDTH-bit add/subtract by sequencing one SLICE-bit ripple adder slice over WIDTH/SLICE cycles, carrying between slices in a register.
- Area-reduced alternative to the fully parallel 32-bit adder built from four 8-bit slices.
- Sits between an issuing unit (start/done handshake) and the register file or ALU result bus.
- Produces sum, carry-out and signed overflow, and holds them until the next operation.

Parameters:
- WIDTH, 32, total operand width; must be a multiple of SLICE.
- SLICE, 8, bits processed per cycle. NSLICE = WIDTH/SLICE (4 by default).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0 = x+y+cin; 1 = x-y (y inverted, carry-in forced to 1, cin ignored). Captured with start.
- x  input  WIDTH  operand A, captured at the accepting edge.
- y  input  WIDTH  operand B, captured at the accepting edge.
- cin  input  1  carry-in, captured at the accepting edge.
- busy  output  1  high while slices are being computed.
- done  output  1  one-cycle pulse when the result registers update.
- sum  output  WIDTH  registered result.
- cout  output  1  carry out of the MSB slice.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, slice index=0, carry reg=0, operand regs=0.
- States: IDLE, RUN.
  - IDLE: start=1 at edge E moves to RUN. At E: latch x into opA; latch y (or ~y if sub) into opB; latch carry = sub ? 1 : cin; idx=0; set op_sub.
  - RUN: at each edge, slice idx computes {c, s} = opA[idx] + opB[idx] + carry. s is written to the working register slice idx, carry <= c, idx increments.
  - RUN exit: on the edge computing idx = NSLICE-1, load sum from the working register (with the final slice merged in), load cout, load ovf, and return to IDLE.
- Timing:
  - busy=1 between edges E and E+NSLICE.
  - done=1 only between edges E+NSLICE and E+NSLICE+1.
  - Latency from the accepting edge to done is NSLICE cycles. Issue interval is NSLICE+1 cycles, unless start is asserted in the done cycle.
  - start held high in the done cycle (state IDLE) is accepted at that edge. done still pulses for exactly one cycle and busy re-asserts on the next cycle.
- Outputs:
  - sum, cout and ovf change only on the completing edge and hold otherwise, including during a subsequent RUN.
  - Intermediate slices never appear on sum.
- start while busy=1 is ignored, not queued. x, y, sub and cin may change freely during RUN without affecting the result.
- Overflow: the carry into the MSB comes from the top bit of the final slice's internal carry chain. ovf is computed identically for add and sub.
- Arithmetic is modulo 2^WIDTH; cout is the raw carry. For sub, cout=1 means no borrow.
- rst asserted mid-RUN aborts immediately: outputs return to reset values, no done pulse, next start behaves as from reset.
- Slice-index counter wraps only through the RUN→IDLE transition; it never exceeds NSLICE-1.

Test Plan:
- Reset, then start with x=0x0000_0001, y=0x0000_0002, cin=0, sub=0 → done exactly 4 cycles after the accepting edge; sum=0x0000_0003, cout=0, ovf=0; busy high for 4 cycles.
- x=0xFFFF_FFFF, y=0x0000_0000, cin=1 → sum=0x0000_0000, cout=1, ovf=0 (carry ripples through all 4 slices).
- Signed overflow: x=0x7FFF_FFFF, y=0x0000_0001, add → sum=0x8000_0000, cout=0, ovf=1. Subtract: x=0x8000_0000, y=0x0000_0001, sub=1 → sum=0x7FFF_FFFF, cout=1, ovf=1.
- Back-to-back issue: hold start=1 with new operands (x=5, y=3, sub=1) through the done cycle → second op accepted at that edge, sum=0x0000_0002, cout=1. Start pulses during busy are ignored, and operand changes during RUN do not alter the result.
- Assert rst for one cycle at cycle 2 of a RUN → busy, done, sum, cout and ovf are all 0 immediately. No done pulse appears afterward. The next op (x=0x0000_00FF, y=0x0000_0001) gives sum=0x0000_0100.
